// File: rtl/inst_stream_encoder_pkg.sv
// Shared defines for the MIPS control decoder and the instruction stream encoder:
// opcode constants, expected control vectors and the encoder FSM state type.
package inst_stream_encoder_pkg;

  // Opcodes
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_J       = 6'b000010;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_SLTI    = 6'b001010;
  localparam logic [5:0] EXE_SLTIU   = 6'b001011;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_XORI    = 6'b001110;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_SW      = 6'b101011;

  // Control vector order: {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump}
  localparam logic [6:0] CTRL_RTYPE = 7'b1100000;
  localparam logic [6:0] CTRL_ALUI  = 7'b1010000;
  localparam logic [6:0] CTRL_BEQ   = 7'b0001000;
  localparam logic [6:0] CTRL_LW    = 7'b1010010;
  localparam logic [6:0] CTRL_SW    = 7'b0010100;
  localparam logic [6:0] CTRL_J     = 7'b0000001;
  localparam logic [6:0] CTRL_NONE  = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

endpackage

// File: rtl/inst_stream_encoder_pack.sv
// mips_inst_pack: combinational field packer. Selects the instruction format
// from the opcode, builds the 32-bit word and the control vector the decoder
// is expected to produce. Unknown opcodes come back with legal=0.
module mips_inst_pack
  import inst_stream_encoder_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        legal,
  output logic [31:0] word,
  output logic [6:0]  exp_ctrl
);

  // Format select and control lookup
  always_comb begin
    legal    = 1'b1;
    word     = {op, rs, rt, imm};
    exp_ctrl = CTRL_NONE;
    case (op)
      EXE_SPECIAL: begin
        word     = {op, rs, rt, rd, shamt, funct};
        exp_ctrl = CTRL_RTYPE;
      end
      EXE_ADDI, EXE_ADDIU, EXE_SLTI, EXE_SLTIU,
      EXE_ANDI, EXE_ORI, EXE_XORI, EXE_LUI:
        exp_ctrl = CTRL_ALUI;
      EXE_BEQ: exp_ctrl = CTRL_BEQ;
      EXE_LW:  exp_ctrl = CTRL_LW;
      EXE_SW:  exp_ctrl = CTRL_SW;
      EXE_J: begin
        word     = {op, target};
        exp_ctrl = CTRL_J;
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/inst_stream_encoder.sv
// inst_stream_encoder: accepts instruction field bundles, packs them and streams
// the words into instruction memory at consecutive addresses, together with the
// control vector the decoder should produce for each word.
module inst_stream_encoder
  import inst_stream_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        in_op,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [6:0]        exp_ctrl,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              overflow
);

  enc_state_t        state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [6:0]        ctrl_q;

  logic              pk_legal;
  logic [31:0]       pk_word;
  logic [6:0]        pk_ctrl;
  logic              accept, wr_done, load, sess_start;

  mips_inst_pack u_pack (
    .op       (in_op),
    .funct    (in_funct),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .shamt    (in_shamt),
    .imm      (in_imm),
    .target   (in_target),
    .legal    (pk_legal),
    .word     (pk_word),
    .exp_ctrl (pk_ctrl)
  );

  // A single output register: a new bundle may enter whenever the register is
  // empty or its word is leaving on this edge, so the stream runs without bubbles.
  assign in_ready   = (state_q == ST_RUN) && (!we_q || imem_ready);
  assign accept     = in_valid && in_ready;
  assign wr_done    = we_q && imem_ready;
  assign load       = accept && pk_legal;
  assign sess_start = start && (state_q == ST_IDLE || state_q == ST_DONE);

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign exp_ctrl   = ctrl_q;

  // Session FSM with registered done/busy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) begin
          state_q <= ST_RUN;
          done    <= 1'b0;
          busy    <= 1'b1;
        end
        ST_RUN: if (accept && in_last) begin
          // An illegal final bundle leaves nothing pending: finish at once.
          if (load) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        ST_DRAIN: if (!we_q || wr_done) begin
          state_q <= ST_DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on accept of a legal bundle, empty on completion
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      ctrl_q  <= 7'h0;
    end else if (load) begin
      we_q    <= 1'b1;
      wdata_q <= pk_word;
      ctrl_q  <= pk_ctrl;
    end else if (wr_done) begin
      we_q    <= 1'b0;
    end
  end

  // Write address, saturating counters and sticky wrap flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      wr_count  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else if (sess_start) begin
      addr_q    <= base_addr;
      wr_count  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_done) begin
        addr_q <= addr_q + 1'b1;
        if (&addr_q) overflow <= 1'b1;
        if (!(&wr_count)) wr_count <= wr_count + 1'b1;
      end
      if (accept && !pk_legal && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Directed bench for inst_stream_encoder with hand-computed expected words.
module tb_inst_stream_encoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [5:0]  in_op = '0, in_funct = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        imem_ready = 1'b1;
  logic        in_ready, imem_we, done, busy, overflow;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  exp_ctrl;
  logic [15:0] wr_count, err_count;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mon_addr[$];
  logic [31:0] mon_data[$];

  inst_stream_encoder #(.ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_op(in_op), .in_funct(in_funct), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .exp_ctrl(exp_ctrl), .done(done), .busy(busy),
    .wr_count(wr_count), .err_count(err_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Record every write that completes on the following rising edge
  always @(negedge clk)
    if (resetn && imem_we && imem_ready) begin
      mon_addr.push_back(imem_addr);
      mon_data.push_back(imem_wdata);
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] b);
    base_addr = b; start = 1'b1;
    tick;
    start = 1'b0;
    mon_addr.delete(); mon_data.delete();
  endtask

  task automatic set_fields(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_funct = fn;
    in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    int n = 0;
    set_fields(op, rs, rt, rd, sh, fn, imm, tgt, last);
    while (!in_ready && n < 20) begin tick; n++; end
    chk("send_ready", in_ready, 1'b1);
    tick;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 30) begin tick; n++; end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_we", imem_we, 0);   chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);    chk("rst_ready", in_ready, 0);
    chk("rst_wrc", wr_count, 0); chk("rst_ovf", overflow, 0);
    resetn = 1'b1;
    tick;

    // R-type add $3,$1,$2
    do_start(8'h10);
    chk("r_busy", busy, 1);
    send(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b1);
    chk("r_we", imem_we, 1);       chk("r_addr", imem_addr, 8'h10);
    chk("r_wdata", imem_wdata, 32'h00221820);
    chk("r_ctrl", exp_ctrl, 7'b1100000);
    tick;
    chk("r_done", done, 1);  chk("r_wrc", wr_count, 1);
    chk("r_we_off", imem_we, 0); chk("r_busy_off", busy, 0);
    tick; tick;
    chk("r_done_held", done, 1);

    // Back-to-back addi / lw, no bubble
    do_start(8'h00);
    chk("bb_done_clr", done, 0);
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0);
    chk("bb0_addr", imem_addr, 8'h00); chk("bb0_wdata", imem_wdata, 32'h20220005);
    chk("bb0_ctrl", exp_ctrl, 7'b1010000);
    send(6'b100011, 5'd29, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0004, 26'h0, 1'b1);
    chk("bb1_we", imem_we, 1);   chk("bb1_addr", imem_addr, 8'h01);
    chk("bb1_wdata", imem_wdata, 32'h8FA80004); chk("bb1_ctrl", exp_ctrl, 7'b1010010);
    wait_done("bb_done");
    chk("bb_wrc", wr_count, 2);

    // Jump
    do_start(8'h20);
    send(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000100, 1'b1);
    chk("j_wdata", imem_wdata, 32'h08000100); chk("j_ctrl", exp_ctrl, 7'b0000001);
    wait_done("j_done");

    // Back-pressure: two bundles, memory stalls 3 cycles
    do_start(8'h30);
    imem_ready = 1'b0;
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 1'b0);
    set_fields(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_lo", in_ready, 0); chk("bp_we", imem_we, 1);
      chk("bp_addr", imem_addr, 8'h30); chk("bp_wdata", imem_wdata, 32'h20220001);
      tick;
    end
    imem_ready = 1'b1;
    #1;
    chk("bp_ready_hi", in_ready, 1);
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp1_addr", imem_addr, 8'h31); chk("bp1_wdata", imem_wdata, 32'h20220002);
    wait_done("bp_done");
    chk("bp_nwr", mon_addr.size(), 2);
    chk("bp_m0", {mon_addr[0], mon_data[0]}, {8'h30, 32'h20220001});
    chk("bp_m1", {mon_addr[1], mon_data[1]}, {8'h31, 32'h20220002});
    chk("bp_wrc", wr_count, 2);

    // Illegal op between two legal bundles
    do_start(8'h40);
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0007, 26'h0, 1'b0);
    send(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0009, 26'h0, 1'b1);
    wait_done("il_done");
    chk("il_nwr", mon_addr.size(), 2);
    chk("il_m0", {mon_addr[0], mon_data[0]}, {8'h40, 32'h20220007});
    chk("il_m1", {mon_addr[1], mon_data[1]}, {8'h41, 32'h20220009});
    chk("il_err", err_count, 1); chk("il_wrc", wr_count, 2);

    // Illegal op as last bundle
    do_start(8'h50);
    send(6'h3F, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b1);
    chk("il2_done", done, 1);    chk("il2_we", imem_we, 0);
    chk("il2_err", err_count, 1); chk("il2_wrc", wr_count, 0);
    tick;
    chk("il2_nwr", mon_addr.size(), 0);

    // Address wrap
    do_start(8'hFF);
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0, 1'b0);
    send(6'b001000, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0, 1'b1);
    wait_done("wr_done");
    chk("wr_nwr", mon_addr.size(), 2);
    chk("wr_a0", mon_addr[0], 8'hFF); chk("wr_a1", mon_addr[1], 8'h00);
    chk("wr_ovf", overflow, 1);

    // Reset mid-write
    do_start(8'h60);
    chk("ovf_clr", overflow, 0);
    imem_ready = 1'b0;
    send(6'b000010, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000040, 1'b1);
    chk("rs_we_pre", imem_we, 1);
    #1 resetn = 1'b0;
    #1;
    chk("rs_we_async", imem_we, 0);
    #10 resetn = 1'b1;
    imem_ready = 1'b1;
    tick;
    chk("rs_busy", busy, 0); chk("rs_done", done, 0);
    chk("rs_wrc", wr_count, 0); chk("rs_err", err_count, 0);
    chk("rs_we", imem_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_stream_encoder.md
Name: inst_stream_encoder

Overview:
- Inverse of the main control decoder: accepts instruction fields (op, funct, registers, immediate, target) over a valid/ready handshake and packs them into 32-bit MIPS words.
- Writes the packed words sequentially into instruction memory through a stallable write port.
- Emits, alongside each word, the 7-bit control vector the decoder must produce for it, so the instruction RAM can be loaded and the decoder scoreboarded in one pass.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; address wraps mod 2^ADDR_W.
- CNT_W, 16, width of write and error counters.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load session
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_last  in  1  bundle is final of session
- in_op  in  6  opcode
- in_funct  in  6  R-type funct
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_shamt  in  5  shift amount
- in_imm  in  16  immediate
- in_target  in  26  jump target
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  packed instruction
- exp_ctrl  out  7  expected {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump}, valid with imem_we
- done  out  1  session complete, held until next start
- busy  out  1  session in progress
- wr_count  out  CNT_W  words written this session
- err_count  out  CNT_W  illegal bundles dropped this session
- overflow  out  1  sticky; address wrapped this session

Behaviour:
- Reset: all outputs 0; FSM to IDLE; output register empty. Reset mid-session aborts immediately: pending write discarded, imem_we drops asynchronously.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE: in_ready=0. On start: addr<=base_addr; wr_count, err_count, overflow<=0; done<=0; go to RUN.
  - RUN: in_ready = !imem_we || imem_ready (single output register, full throughput). A bundle accepted with in_last=1 moves the FSM to DRAIN.
  - DRAIN: in_ready=0. Go to DONE once no write is pending; this can be the same cycle as entry if the last bundle was illegal.
  - start outside IDLE/DONE is ignored.
- Formats, selected by in_op:
  - 000000 -> {op,rs,rt,rd,shamt,funct}; exp_ctrl 1100000.
  - 001000/001001/001010/001011/001100/001101/001110/001111 -> {op,rs,rt,imm}; exp_ctrl 1010000.
  - 000100 -> I format; exp_ctrl 0001000.
  - 100011 -> I format; exp_ctrl 1010010.
  - 101011 -> I format; exp_ctrl 0010100.
  - 000010 -> {op,target}; exp_ctrl 0000001.
  - Any other op is illegal: accepted (handshake completes), not written, err_count+1.
- Latency:
  - Bundle accepted at edge N -> imem_we=1 with addr/wdata/exp_ctrl during cycle N+1.
  - A write completes on an edge where imem_we && imem_ready; on that edge addr+1 and wr_count+1.
  - imem_we, addr, wdata and exp_ctrl are held stable while imem_ready=0.
- Simultaneous completion and acceptance: output register reloads with no bubble.
- Wrap: a write completing at addr all-ones -> addr<=0, overflow<=1 (sticky until next start).
- Counters saturate at all-ones.
- in_* fields are ignored whenever in_valid=0 or in_ready=0.

Decomposition:
- Opcode constants (EXE_* names) and the 7-bit expected-control constants belong in the shared defines header already used by the decoder; the same values are shared by both blocks.
- Sub-module mips_inst_pack: purely combinational; takes fields, returns {legal, word[31:0], exp_ctrl[6:0]}.
- inst_stream_encoder holds the FSM, output register, address and counters.

Test Plan:
- R-type: start base=0x10; op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, last -> next cycle imem_we=1, addr=0x10, wdata=0x00221820, exp_ctrl=1100000; after completion done=1, wr_count=1.
- I-types back-to-back with imem_ready=1:
  - addi rs=1, rt=2, imm=5 -> 0x20220005, exp 1010000, addr 0x00.
  - lw rs=29, rt=8, imm=4 -> 0x8FA80004, exp 1010010, addr 0x01.
  - No idle cycle between the two writes.
- Jump: op=000010, target=0x0000100 -> wdata=0x08000100, exp_ctrl=0000001.
- Back-pressure: two bundles queued, imem_ready=0 for 3 cycles:
  - in_ready=0 while the first write is pending.
  - addr/wdata held stable; no word lost or duplicated; addresses consecutive.
- Illegal op: op=0x3F between two legal bundles -> exactly 2 writes at consecutive addresses, err_count=1.
- Illegal op as last bundle -> done without a write.
- Wrap and reset:
  - base=0xFF with two words -> addresses 0xFF then 0x00, overflow=1.
  - resetn pulled low mid-write -> imem_we=0 immediately; after release busy=0, done=0, counters 0.
